cpu_bus_sync: RTL and testbench
===============================

CPU_BUS_SYNC -- requirements
Module: cpu_bus_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the depth of the M2 synchroniser (minimum 2).
REQ-002 Parameter SETTLE_CYCLES, default 2, SHALL set the number of SYSCLK cycles M2 must be seen high before the cycle is qualified (range 1..15).
REQ-003 Parameter WDOG_CYCLES, default 255, SHALL set the M2-stall limit in SYSCLK cycles (8-bit counter).
REQ-004 Port SYSCLK, input, 1 bit: single clock; all state on its rising edge.
REQ-005 Port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 Ports M2, nROMSEL, CPU_RW, input, 1 bit each: raw NES CPU bus controls, asynchronous to SYSCLK.
REQ-007 Ports CPU_A [14:0] and CPU_D [7:0], input: raw CPU address and data.
REQ-008 Port BUS_A, output, 16 bits: qualified address, with BUS_A[15] = !nROMSEL.
REQ-009 Port BUS_D, output, 8 bits: qualified write data.
REQ-010 Ports WR_STB and RD_STB, output, 1 bit each: one-SYSCLK-cycle strobes, once per qualified CPU cycle.
REQ-011 Port CYC_ACTIVE, output, 1 bit: high while in state ACTIVE.
REQ-012 Port M2_LOST, output, 1 bit: watchdog flag (see Configuration).

Function
REQ-013 M2 SHALL pass through SYNC_STAGES flops to give m2_s; m2_d is m2_s delayed one cycle; rise = m2_s & !m2_d; fall = !m2_s & m2_d.
REQ-014 CPU_A, CPU_D, CPU_RW and nROMSEL SHALL be registered each cycle into bus_q; the shadow copy SHALL load from bus_q every cycle that m2_s=1.
REQ-015 FSM states SHALL be WAIT_LOW, IDLE, SETTLE and ACTIVE.
REQ-016 WAIT_LOW SHALL go to IDLE when m2_s=0.
REQ-017 IDLE SHALL go to SETTLE on rise and clear the settle counter.
REQ-018 SETTLE SHALL count while m2_s=1 and go to ACTIVE when the count reaches SETTLE_CYCLES; fall in SETTLE SHALL return to IDLE with no strobe (glitch reject).
REQ-019 On entry to ACTIVE with shadow RW=1, RD_STB SHALL pulse for exactly one cycle, with BUS_A taken from the shadow.
REQ-020 In ACTIVE, fall with shadow RW=0 SHALL pulse WR_STB for one cycle, registered on the next edge, with BUS_A/BUS_D = shadow values (last sample taken while m2_s=1); ACTIVE then goes to IDLE.
REQ-021 In ACTIVE, fall with RW=1 SHALL go to IDLE with no further strobe.
REQ-022 At most one strobe SHALL occur per M2 high period, and WR_STB and RD_STB SHALL never assert together.
REQ-023 BUS_A and BUS_D SHALL hold their last strobed values between strobes.
REQ-024 Correct write capture requires SYSCLK >= 8x the M2 frequency; this is a stated operating constraint, not checked by the block.

Reset
REQ-025 RST=1 SHALL force state WAIT_LOW, clear the synchroniser, and drive BUS_A=16'h0000, BUS_D=8'h00, WR_STB=0, RD_STB=0, CYC_ACTIVE=0, M2_LOST=0.
REQ-026 Reset asserted mid-cycle SHALL abort that cycle with no strobe.
REQ-027 After reset, no strobe SHALL occur until m2_s has been seen low (WAIT_LOW), even if M2 is high when reset releases.

Configuration
REQ-028 Macro CPU_BUS_SYNC_WDOG_EN defined: an 8-bit counter SHALL clear on each rise and fall, and set M2_LOST once it reaches WDOG_CYCLES with no M2 edge.
REQ-029 With the watchdog enabled, M2_LOST set SHALL force state WAIT_LOW; the flag SHALL clear on the next rise.
REQ-030 Macro undefined: no counter SHALL be built and M2_LOST SHALL be tied to 0.

Structure
REQ-031 Package nespc_pkg SHALL hold the FSM state enum (bus_state_t) and the constants NES_IO_BASE=16'h4000 and NES_PRG_BASE=16'h8000.
REQ-032 The M2 synchroniser SHALL be a separate sub-module, sync_ff, parameterised by SYNC_STAGES.

Verification
REQ-033 Write: M2 high for 12 SYSCLK cycles, nROMSEL=1, CPU_A=15'h4030, CPU_D=8'h5A, RW=0 -> one WR_STB, 3 SYSCLK edges after M2 falls (2 sync + 1 edge-detect), with BUS_A=16'h4030 and BUS_D=8'h5A, and no RD_STB.
REQ-034 Read: nROMSEL=0, CPU_A=15'h7FFC, RW=1, M2 high for 12 cycles -> one RD_STB with BUS_A=16'hFFFC, CYC_ACTIVE high until M2 falls, and no WR_STB.
REQ-035 Glitch: M2 high for 1 cycle with SETTLE_CYCLES=2 -> no strobe, and state returns to IDLE.
REQ-036 Reset: RST asserted mid-write and released with M2 still high -> no strobe for that cycle; the next full write with CPU_D=8'hA5 gives BUS_D=8'hA5.
REQ-037 Watchdog (CPU_BUS_SYNC_WDOG_EN defined): M2 held high for 300 cycles -> M2_LOST=1 at cycle 255+sync latency; M2_LOST clears on the next rise; with the macro undefined, M2_LOST stays 0.

Source files
------------

// File: rtl/nespc_pkg.sv
// nespc_pkg -- shared types and constants for the NES CPU bus front end.
//   bus_state_t  : state encoding of the cpu_bus_sync qualifier FSM
//   bus_smp_t    : one registered sample of the raw CPU bus controls
//   NES_IO_BASE  : start of the CPU I/O register window
//   NES_PRG_BASE : start of the cartridge PRG window (selected by nROMSEL)
//   cpu_addr()   : rebuilds the 16-bit CPU address from a bus sample
package nespc_pkg;

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      IDLE     = 2'd1,
      SETTLE   = 2'd2,
      ACTIVE   = 2'd3
   } bus_state_t;

   localparam logic [15:0] NES_IO_BASE  = 16'h4000;
   localparam logic [15:0] NES_PRG_BASE = 16'h8000;

   typedef struct packed {
      logic        nromsel;
      logic        rw;
      logic [14:0] a;
      logic [7:0]  d;
   } bus_smp_t;

   // The CPU never drives A15 to the cartridge; nROMSEL low is A15 high.
   function automatic logic [15:0] cpu_addr(input bus_smp_t s);
      return s.nromsel ? {1'b0, s.a} : (NES_PRG_BASE | {1'b0, s.a});
   endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff -- multi-flop synchroniser for one asynchronous control bit.
//   SYNC_STAGES : number of flops in the chain (at least 2)
//   SYSCLK      : destination clock
//   RST         : synchronous active-high reset, clears the chain to 0
//   d           : asynchronous input
//   q           : synchronised output
module sync_ff #(
   parameter int SYNC_STAGES = 2
) (
   input  logic SYSCLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge SYSCLK) begin
      if (RST) chain <= '0;
      else     chain <= {chain[SYNC_STAGES-2:0], d};
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_bus_sync.sv
// cpu_bus_sync -- qualifies raw NES CPU bus cycles into SYSCLK-domain strobes.
//   SYSCLK, RST          : clock and synchronous active-high reset
//   M2, nROMSEL, CPU_RW  : raw CPU bus controls (asynchronous)
//   CPU_A[14:0], CPU_D   : raw CPU address and data
//   BUS_A[15:0], BUS_D   : address / write data of the last strobed cycle
//   WR_STB, RD_STB       : one-cycle strobes, at most one per M2 high period
//   CYC_ACTIVE           : high while a qualified cycle is in progress
//   M2_LOST              : M2 stall flag
// Build option: define CPU_BUS_SYNC_WDOG_EN to build the M2 stall watchdog;
// without it M2_LOST is tied low. Assumes SYSCLK >= 8x the M2 frequency.
module cpu_bus_sync
   import nespc_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int WDOG_CYCLES   = 255
) (
   input  logic        SYSCLK,
   input  logic        RST,
   input  logic        M2,
   input  logic        nROMSEL,
   input  logic        CPU_RW,
   input  logic [14:0] CPU_A,
   input  logic [7:0]  CPU_D,
   output logic [15:0] BUS_A,
   output logic [7:0]  BUS_D,
   output logic        WR_STB,
   output logic        RD_STB,
   output logic        CYC_ACTIVE,
   output logic        M2_LOST
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..15");
   end
   if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_bad_wdog
      $error("WDOG_CYCLES must be in 1..255");
   end

   logic                 m2_s, m2_d, rise, fall;
   logic [SYNC_STAGES:0] prime;
   logic                 primed;
   bus_smp_t             bus_q, shadow;
   bus_state_t           state, state_nx;
   logic [3:0]           settle_cnt, settle_nx;
   logic                 rd_go, wr_go, wdog_trip;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_m2_sync (
      .SYSCLK (SYSCLK),
      .RST    (RST),
      .d      (M2),
      .q      (m2_s)
   );

   assign rise = m2_s & ~m2_d;
   assign fall = ~m2_s & m2_d;

   // The synchroniser comes out of reset reading 0 whatever M2 is doing, so
   // WAIT_LOW only trusts m2_s once the chain has refilled from the pin.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         m2_d  <= 1'b0;
         prime <= '0;
      end else begin
         m2_d  <= m2_s;
         prime <= {prime[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign primed = prime[SYNC_STAGES];

   // Bus sample stage; the shadow keeps the last sample seen while M2 high.
   always_ff @(posedge SYSCLK) begin
      bus_q <= {nROMSEL, CPU_RW, CPU_A, CPU_D};
      if (m2_s) shadow <= bus_q;
   end

`ifdef CPU_BUS_SYNC_WDOG_EN
   logic [7:0] wdog_cnt;
   logic       m2_lost;

   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         wdog_cnt <= '0;
         m2_lost  <= 1'b0;
      end else begin
         if (rise || fall)                       wdog_cnt <= '0;
         else if (wdog_cnt != 8'(WDOG_CYCLES))   wdog_cnt <= wdog_cnt + 8'd1;
         if (rise)                               m2_lost  <= 1'b0;
         else if (wdog_cnt == 8'(WDOG_CYCLES))   m2_lost  <= 1'b1;
      end
   end

   // The counter stays saturated for the whole stall, holding the FSM in
   // WAIT_LOW until M2 moves again.
   assign wdog_trip = (wdog_cnt == 8'(WDOG_CYCLES)) && !rise && !fall;
   assign M2_LOST   = m2_lost;
`else
   assign wdog_trip = 1'b0;
   assign M2_LOST   = 1'b0;
`endif

   always_comb begin
      state_nx  = state;
      settle_nx = settle_cnt;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      case (state)
         WAIT_LOW: if (primed && !m2_s) state_nx = IDLE;
         IDLE: begin
            if (rise) begin
               state_nx  = SETTLE;
               settle_nx = '0;
            end
         end
         SETTLE: begin
            if (fall) begin
               state_nx = IDLE;
            end else if (m2_s) begin
               settle_nx = settle_cnt + 4'd1;
               if (settle_nx == 4'(SETTLE_CYCLES)) begin
                  state_nx = ACTIVE;
                  rd_go    = shadow.rw;
               end
            end
         end
         ACTIVE: begin
            if (fall) begin
               state_nx = IDLE;
               wr_go    = ~shadow.rw;
            end
         end
         default: state_nx = WAIT_LOW;
      endcase
      if (wdog_trip) begin
         state_nx = WAIT_LOW;
         rd_go    = 1'b0;
         wr_go    = 1'b0;
      end
   end

   // BUS_D only follows writes; a read cycle leaves the last write data.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         state      <= WAIT_LOW;
         settle_cnt <= '0;
         RD_STB     <= 1'b0;
         WR_STB     <= 1'b0;
         BUS_A      <= 16'h0000;
         BUS_D      <= 8'h00;
      end else begin
         state      <= state_nx;
         settle_cnt <= settle_nx;
         RD_STB     <= rd_go;
         WR_STB     <= wr_go;
         if (rd_go || wr_go) BUS_A <= cpu_addr(shadow);
         if (wr_go)          BUS_D <= shadow.d;
      end
   end

   assign CYC_ACTIVE = (state == ACTIVE);

endmodule

// File: tb/tb_cpu_bus_sync.sv
// tb_cpu_bus_sync -- scoreboard bench for cpu_bus_sync: stimulus pushes the
// strobes it expects, a negedge monitor pops and compares them.
module tb_cpu_bus_sync;
   import nespc_pkg::*;

   logic        SYSCLK = 1'b0;
   logic        RST = 1'b1;
   logic        M2 = 1'b0;
   logic        nROMSEL = 1'b1;
   logic        CPU_RW = 1'b1;
   logic [14:0] CPU_A = '0;
   logic [7:0]  CPU_D = '0;
   logic [15:0] BUS_A;
   logic [7:0]  BUS_D;
   logic        WR_STB, RD_STB, CYC_ACTIVE, M2_LOST;

   cpu_bus_sync dut (
      .SYSCLK     (SYSCLK),
      .RST        (RST),
      .M2         (M2),
      .nROMSEL    (nROMSEL),
      .CPU_RW     (CPU_RW),
      .CPU_A      (CPU_A),
      .CPU_D      (CPU_D),
      .BUS_A      (BUS_A),
      .BUS_D      (BUS_D),
      .WR_STB     (WR_STB),
      .RD_STB     (RD_STB),
      .CYC_ACTIVE (CYC_ACTIVE),
      .M2_LOST    (M2_LOST)
   );

   always #5 SYSCLK = ~SYSCLK;

   typedef struct {
      bit          is_wr;
      logic [15:0] a;
      logic [7:0]  d;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          m2_hi_tb = 0;
   logic [15:0] last_a = '0;
   logic [7:0]  last_d = '0;

   always @(posedge SYSCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge SYSCLK) begin : monitor
      exp_t e;
      if (WR_STB === 1'b1 || RD_STB === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_stb", 32'({WR_STB, RD_STB}), 32'd0);
         end else begin
            e = sb.pop_front();
            check("stb_kind", 32'({WR_STB, RD_STB}), e.is_wr ? 32'd2 : 32'd1);
            check("bus_a", 32'(BUS_A), 32'(e.a));
            if (e.is_wr) begin
               check("bus_d", 32'(BUS_D), 32'(e.d));
               check("wr_latency", 32'(cyc), 32'(e.due));
            end else begin
               check("rd_in_high", 32'(m2_hi_tb), 32'd1);
               check("cyc_active_rd", 32'(CYC_ACTIVE), 32'd1);
            end
         end
      end
   end

   function automatic logic [15:0] model_addr(input bit nrom, input logic [14:0] a);
      return {~nrom, a};
   endfunction

   task automatic check_hold();
      check("hold_a", 32'(BUS_A), 32'(last_a));
      check("hold_d", 32'(BUS_D), 32'(last_d));
   endtask

   task automatic bus_cycle(input bit rw, input bit nrom, input logic [14:0] a,
                            input logic [7:0] d, input int hi, input bit expect_stb);
      exp_t e;
      @(negedge SYSCLK);
      CPU_RW = rw; nROMSEL = nrom; CPU_A = a; CPU_D = d;
      repeat (2) @(negedge SYSCLK);
      M2 = 1'b1; m2_hi_tb = 1;
      if (expect_stb && rw) begin
         e = '{is_wr: 1'b0, a: model_addr(nrom, a), d: 8'h00, due: -1};
         sb.push_back(e);
      end
      repeat (hi) @(negedge SYSCLK);
      if (expect_stb) check("cyc_active_hi", 32'(CYC_ACTIVE), 32'd1);
      M2 = 1'b0; m2_hi_tb = 0;
      if (expect_stb && !rw) begin
         e = '{is_wr: 1'b1, a: model_addr(nrom, a), d: d, due: cyc + 3};
         sb.push_back(e);
      end
      repeat (6) @(negedge SYSCLK);
      check("cyc_active_lo", 32'(CYC_ACTIVE), 32'd0);
      if (expect_stb) begin
         last_a = model_addr(nrom, a);
         if (!rw) last_d = d;
      end
      check_hold();
   endtask

   task automatic check_reset_outputs();
      check("rst_bus_a", 32'(BUS_A), 32'h0000);
      check("rst_bus_d", 32'(BUS_D), 32'h00);
      check("rst_wr", 32'(WR_STB), 32'd0);
      check("rst_rd", 32'(RD_STB), 32'd0);
      check("rst_cyc_active", 32'(CYC_ACTIVE), 32'd0);
      check("rst_m2_lost", 32'(M2_LOST), 32'd0);
   endtask

   initial begin : timeout
      #200000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int rise_cyc, lost_cyc, lost_hi;
      bit seen;
      exp_t e;

      repeat (3) @(negedge SYSCLK);
      check_reset_outputs();
      RST = 1'b0;
      repeat (4) @(negedge SYSCLK);

      bus_cycle(1'b0, 1'b1, 15'h4030, 8'h5A, 12, 1'b1);
      bus_cycle(1'b1, 1'b0, 15'h7FFC, 8'h00, 12, 1'b1);
      bus_cycle(1'b0, 1'b0, 15'h0000, 8'hFF, 12, 1'b1);
      bus_cycle(1'b1, 1'b1, 15'(NES_IO_BASE) + 15'h0016, 8'h00, 12, 1'b1);

      bus_cycle(1'b0, 1'b1, 15'h4030, 8'h11, 1, 1'b0);
      check("glitch_idle", 32'(dut.state), 32'(IDLE));
      bus_cycle(1'b0, 1'b1, 15'h2007, 8'h3C, 12, 1'b1);

      // reset in the middle of a write, released with M2 still high
      @(negedge SYSCLK);
      CPU_RW = 1'b0; nROMSEL = 1'b1; CPU_A = 15'h4014; CPU_D = 8'h77;
      repeat (2) @(negedge SYSCLK);
      M2 = 1'b1; m2_hi_tb = 1;
      repeat (6) @(negedge SYSCLK);
      RST = 1'b1;
      repeat (2) @(negedge SYSCLK);
      check_reset_outputs();
      last_a = '0; last_d = '0;
      RST = 1'b0;
      repeat (8) @(negedge SYSCLK);
      check("post_rst_no_cyc", 32'(CYC_ACTIVE), 32'd0);
      M2 = 1'b0; m2_hi_tb = 0;
      repeat (6) @(negedge SYSCLK);
      check_hold();
      bus_cycle(1'b0, 1'b1, 15'h4030, 8'hA5, 12, 1'b1);

      // M2 stall
      @(negedge SYSCLK);
      CPU_RW = 1'b1; nROMSEL = 1'b0; CPU_A = 15'h0123;
      repeat (2) @(negedge SYSCLK);
      M2 = 1'b1; m2_hi_tb = 1;
      rise_cyc = cyc;
      e = '{is_wr: 1'b0, a: 16'h8123, d: 8'h00, due: -1};
      sb.push_back(e);
      seen = 0; lost_cyc = 0; lost_hi = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge SYSCLK);
         if (M2_LOST === 1'b1) begin
            lost_hi++;
            if (!seen) begin seen = 1; lost_cyc = cyc; end
         end
      end
`ifdef CPU_BUS_SYNC_WDOG_EN
      check("m2_lost_set", 32'(seen), 32'd1);
      check("m2_lost_time", 32'((lost_cyc - rise_cyc) >= 255 && (lost_cyc - rise_cyc) <= 262), 32'd1);
      check("m2_lost_forces_wait", 32'(CYC_ACTIVE), 32'd0);
`else
      check("m2_lost_tied", 32'(lost_hi), 32'd0);
`endif
      M2 = 1'b0; m2_hi_tb = 0;
      repeat (6) @(negedge SYSCLK);
      last_a = 16'h8123;
      check_hold();
      bus_cycle(1'b0, 1'b1, 15'h4011, 8'hC3, 12, 1'b1);
      check("m2_lost_clear", 32'(M2_LOST), 32'd0);

      repeat (10) @(negedge SYSCLK);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
